// File: rtl/noc_link_pipe.sv
// Pipelined, credit-monitored NoC link: retimes flits forward and credits backward
// by NUM_PIPELINE stages each, and flags credit protocol violations at the upstream port.
module noc_link_pipe #(
  parameter int NUM_PIPELINE      = 1,
  parameter int FLIT_WIDTH        = 64,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CRED_W            = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc_sync,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [CRED_W-1:0]     credits_avail,
  output logic                  in_packet,
  output logic [31:0]           flit_count,
  output logic [31:0]           pkt_count,
  output logic                  err_underflow,
  output logic                  err_overflow
);

  localparam int                FWD_W    = FLIT_WIDTH + DEST_WIDTH + 2;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FLIT_BUFFER_DEPTH);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

  logic [FWD_W-1:0]  w_fwd_in;
  logic [FWD_W-1:0]  w_fwd_out;
  logic              w_credit_out;

  logic [CRED_W-1:0] r_credits;
  logic [CRED_W-1:0] w_credits_next;
  logic              w_uf_set;
  logic              w_of_set;
  logic              r_err_underflow;
  logic              r_err_overflow;
  logic              r_in_packet;
  logic [31:0]       r_flit_count;
  logic [31:0]       r_pkt_count;

  assign w_fwd_in = {send_in, is_tail_in, dest_in, data_in};

  generate
    if (NUM_PIPELINE == 0) begin : g_wire
      assign w_fwd_out    = w_fwd_in;
      assign w_credit_out = credit_in;
    end else begin : g_pipe
      logic [FWD_W-1:0]        r_fwd [NUM_PIPELINE];
      logic [NUM_PIPELINE-1:0] r_cred;

      // Free-running shift registers; reset clears payload too so nothing stale leaks out.
      always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
          for (int i = 0; i < NUM_PIPELINE; i++) begin
            r_fwd[i] <= '0;
          end
          r_cred <= '0;
        end else begin
          r_fwd[0]  <= w_fwd_in;
          r_cred[0] <= credit_in;
          for (int i = 1; i < NUM_PIPELINE; i++) begin
            r_fwd[i]  <= r_fwd[i-1];
            r_cred[i] <= r_cred[i-1];
          end
        end
      end

      assign w_fwd_out    = r_fwd[NUM_PIPELINE-1];
      assign w_credit_out = r_cred[NUM_PIPELINE-1];
    end
  endgenerate

  assign send_out    = w_fwd_out[FWD_W-1];
  assign is_tail_out = w_fwd_out[FWD_W-2];
  assign dest_out    = w_fwd_out[FLIT_WIDTH +: DEST_WIDTH];
  assign data_out    = w_fwd_out[FLIT_WIDTH-1:0];
  assign credit_out  = w_credit_out;

  // Credit counter next state; saturates at both ends and raises the matching error.
  always_comb begin
    w_credits_next = r_credits;
    w_uf_set       = 1'b0;
    w_of_set       = 1'b0;
    case ({send_in, w_credit_out})
      2'b10: begin
        if (r_credits == '0) begin
          w_uf_set = 1'b1;
        end else begin
          w_credits_next = r_credits - CRED_ONE;
        end
      end
      2'b01: begin
        if (r_credits == CRED_MAX) begin
          w_of_set = 1'b1;
        end else begin
          w_credits_next = r_credits + CRED_ONE;
        end
      end
      default: begin
        w_credits_next = r_credits;
      end
    endcase
  end

  // Monitor state: credit count and sticky error flags.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      r_credits       <= CRED_MAX;
      r_err_underflow <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      r_credits       <= w_credits_next;
      r_err_underflow <= r_err_underflow | w_uf_set;
      r_err_overflow  <= r_err_overflow | w_of_set;
    end
  end

  // Packet tracker; counters wrap silently.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      r_in_packet  <= 1'b0;
      r_flit_count <= 32'd0;
      r_pkt_count  <= 32'd0;
    end else if (send_in) begin
      r_in_packet  <= ~is_tail_in;
      r_flit_count <= r_flit_count + 32'd1;
      r_pkt_count  <= is_tail_in ? (r_pkt_count + 32'd1) : r_pkt_count;
    end else begin
      r_in_packet  <= r_in_packet;
      r_flit_count <= r_flit_count;
      r_pkt_count  <= r_pkt_count;
    end
  end

  assign credits_avail = r_credits;
  assign err_underflow = r_err_underflow;
  assign err_overflow  = r_err_overflow;
  assign in_packet     = r_in_packet;
  assign flit_count    = r_flit_count;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_noc_link_pipe.sv
// Directed bench for noc_link_pipe at NUM_PIPELINE = 2, 4 and 0, all driven by shared inputs.
module tb_noc_link_pipe;

  logic        clk_noc = 1'b0;
  logic        rst_noc_sync;
  logic [63:0] data_in;
  logic [5:0]  dest_in;
  logic        is_tail_in;
  logic        send_in;
  logic        credit_in;

  logic        credit_out_2, is_tail_out_2, send_out_2, in_packet_2, err_uf_2, err_of_2;
  logic [63:0] data_out_2;
  logic [5:0]  dest_out_2;
  logic [2:0]  credits_2;
  logic [31:0] flit_count_2, pkt_count_2;

  logic        credit_out_4, is_tail_out_4, send_out_4, in_packet_4, err_uf_4, err_of_4;
  logic [63:0] data_out_4;
  logic [5:0]  dest_out_4;
  logic [2:0]  credits_4;
  logic [31:0] flit_count_4, pkt_count_4;

  logic        credit_out_0, is_tail_out_0, send_out_0, in_packet_0, err_uf_0, err_of_0;
  logic [63:0] data_out_0;
  logic [5:0]  dest_out_0;
  logic [2:0]  credits_0;
  logic [31:0] flit_count_0, pkt_count_0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_noc = ~clk_noc;

  noc_link_pipe #(.NUM_PIPELINE(2)) u_dut2 (
    .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out_2), .data_out(data_out_2),
    .dest_out(dest_out_2), .is_tail_out(is_tail_out_2), .send_out(send_out_2), .credit_in(credit_in),
    .credits_avail(credits_2), .in_packet(in_packet_2), .flit_count(flit_count_2),
    .pkt_count(pkt_count_2), .err_underflow(err_uf_2), .err_overflow(err_of_2));

  noc_link_pipe #(.NUM_PIPELINE(4)) u_dut4 (
    .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out_4), .data_out(data_out_4),
    .dest_out(dest_out_4), .is_tail_out(is_tail_out_4), .send_out(send_out_4), .credit_in(credit_in),
    .credits_avail(credits_4), .in_packet(in_packet_4), .flit_count(flit_count_4),
    .pkt_count(pkt_count_4), .err_underflow(err_uf_4), .err_overflow(err_of_4));

  noc_link_pipe #(.NUM_PIPELINE(0)) u_dut0 (
    .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out_0), .data_out(data_out_0),
    .dest_out(dest_out_0), .is_tail_out(is_tail_out_0), .send_out(send_out_0), .credit_in(credit_in),
    .credits_avail(credits_0), .in_packet(in_packet_0), .flit_count(flit_count_0),
    .pkt_count(pkt_count_0), .err_underflow(err_uf_0), .err_overflow(err_of_0));

  task automatic idle_inputs;
    send_in    = 1'b0;
    is_tail_in = 1'b0;
    dest_in    = 6'd0;
    data_in    = 64'd0;
    credit_in  = 1'b0;
  endtask

  // Leaves the bench 1 time unit after a rising edge, ready to drive cycle 0.
  task automatic do_reset;
    idle_inputs();
    rst_noc_sync = 1'b1;
    repeat (2) @(posedge clk_noc);
    #1;
    rst_noc_sync = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge clk_noc);
    #1;
  endtask

  task automatic test_reset;
    logic [178:0] v2, v0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      #1;
      v2 = {send_out_2, credit_out_2, is_tail_out_2, data_out_2, dest_out_2, in_packet_2,
            err_uf_2, err_of_2, flit_count_2, pkt_count_2};
      v0 = {send_out_0, credit_out_0, is_tail_out_0, data_out_0, dest_out_0, in_packet_0,
            err_uf_0, err_of_0, flit_count_0, pkt_count_0};
      n_cmp++;
      if (v2 !== 179'd0) begin
        n_fail++;
        $display("FAIL reset_outs_np2 cycle %0d: got %h want 0", k, v2);
      end
      n_cmp++;
      if (v0 !== 179'd0) begin
        n_fail++;
        $display("FAIL reset_outs_np0 cycle %0d: got %h want 0", k, v0);
      end
      n_cmp++;
      if (credits_2 !== 3'd4) begin
        n_fail++;
        $display("FAIL reset_credits cycle %0d: got %0d want 4", k, credits_2);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_flit;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      if (k == 0) begin
        send_in = 1'b1; is_tail_in = 1'b1; dest_in = 6'h2A; data_in = 64'h0000_0000_DEAD_BEEF;
      end
      #1;
      if (k == 1) begin
        n_cmp++;
        if ({credits_2, pkt_count_2, flit_count_2, in_packet_2} !== {3'd3, 32'd1, 32'd1, 1'b0}) begin
          n_fail++;
          $display("FAIL single_monitor: got cred=%0d pkt=%0d flit=%0d inpkt=%0b want 3/1/1/0",
                   credits_2, pkt_count_2, flit_count_2, in_packet_2);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if ({send_out_2, is_tail_out_2, dest_out_2, data_out_2} !==
            {1'b1, 1'b1, 6'h2A, 64'h0000_0000_DEAD_BEEF}) begin
          n_fail++;
          $display("FAIL single_out: got send=%0b tail=%0b dest=%h data=%h want 1/1/2a/deadbeef",
                   send_out_2, is_tail_out_2, dest_out_2, data_out_2);
        end
      end else begin
        n_cmp++;
        if (send_out_2 !== 1'b0) begin
          n_fail++;
          $display("FAIL single_no_send cycle %0d: got %0b want 0", k, send_out_2);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back;
    int unsigned exp_cred [8]  = '{4, 3, 2, 2, 2, 3, 4, 4};
    int unsigned exp_flit [8]  = '{0, 1, 2, 3, 4, 4, 4, 4};
    int unsigned exp_pkt  [8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic        exp_inpk [8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        exp_send;
    logic [63:0] exp_data;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      if (k < 4) begin
        send_in = 1'b1; is_tail_in = (k == 3); dest_in = 6'(k); data_in = 64'h100 + 64'(k);
        credit_in = 1'b1;
      end
      #1;
      exp_send = (k >= 2) && (k <= 5);
      exp_data = exp_send ? (64'h100 + 64'(k - 2)) : 64'd0;
      n_cmp++;
      if ({send_out_2, data_out_2, is_tail_out_2} !== {exp_send, exp_data, (k == 5)}) begin
        n_fail++;
        $display("FAIL b2b_fwd cycle %0d: got send=%0b data=%h tail=%0b want %0b/%h/%0b",
                 k, send_out_2, data_out_2, is_tail_out_2, exp_send, exp_data, (k == 5));
      end
      n_cmp++;
      if (credit_out_2 !== exp_send) begin
        n_fail++;
        $display("FAIL b2b_credit_out cycle %0d: got %0b want %0b", k, credit_out_2, exp_send);
      end
      n_cmp++;
      if ({credits_2, flit_count_2, pkt_count_2, in_packet_2} !==
          {3'(exp_cred[k]), exp_flit[k], exp_pkt[k], exp_inpk[k]}) begin
        n_fail++;
        $display("FAIL b2b_monitor cycle %0d: got cred=%0d flit=%0d pkt=%0d inpkt=%0b want %0d/%0d/%0d/%0b",
                 k, credits_2, flit_count_2, pkt_count_2, in_packet_2,
                 exp_cred[k], exp_flit[k], exp_pkt[k], exp_inpk[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_underflow;
    int unsigned exp_cred [8] = '{4, 3, 2, 1, 0, 0, 0, 0};
    logic        exp_err  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      if (k < 5) begin
        send_in = 1'b1; is_tail_in = 1'b1;
      end
      #1;
      n_cmp++;
      if ({credits_2, err_uf_2, err_of_2} !== {3'(exp_cred[k]), exp_err[k], 1'b0}) begin
        n_fail++;
        $display("FAIL underflow cycle %0d: got cred=%0d uf=%0b of=%0b want %0d/%0b/0",
                 k, credits_2, err_uf_2, err_of_2, exp_cred[k], exp_err[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      idle_inputs();
      credit_in = (k == 0);
      #1;
      n_cmp++;
      if ({credit_out_2, err_of_2, err_uf_2, credits_2} !== {(k == 2), (k >= 3), 1'b0, 3'd4}) begin
        n_fail++;
        $display("FAIL overflow cycle %0d: got cout=%0b of=%0b uf=%0b cred=%0d want %0b/%0b/0/4",
                 k, credit_out_2, err_of_2, err_uf_2, credits_2, (k == 2), (k >= 3));
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_in_flight;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      idle_inputs();
      rst_noc_sync = (k == 2) || (k == 3);
      if (k < 2) begin
        send_in = 1'b1; data_in = 64'(k + 1);
      end
      #1;
      n_cmp++;
      if (send_out_4 !== 1'b0) begin
        n_fail++;
        $display("FAIL inflight_send_out cycle %0d: got %0b want 0", k, send_out_4);
      end
      if (k >= 4) begin
        n_cmp++;
        if ({credits_4, flit_count_4, pkt_count_4, in_packet_4} !== {3'd4, 32'd0, 32'd0, 1'b0}) begin
          n_fail++;
          $display("FAIL inflight_restore cycle %0d: got cred=%0d flit=%0d pkt=%0d inpkt=%0b want 4/0/0/0",
                   k, credits_4, flit_count_4, pkt_count_4, in_packet_4);
        end
      end
      next_cycle();
    end
    rst_noc_sync = 1'b0;
  endtask

  task automatic test_np0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      if (k == 0) begin
        send_in = 1'b1; is_tail_in = 1'b1; dest_in = 6'h15; data_in = 64'h0000_0000_0000_CAFE;
        credit_in = 1'b1;
      end
      #1;
      if (k == 0) begin
        n_cmp++;
        if ({send_out_0, is_tail_out_0, dest_out_0, data_out_0, credit_out_0} !==
            {1'b1, 1'b1, 6'h15, 64'h0000_0000_0000_CAFE, 1'b1}) begin
          n_fail++;
          $display("FAIL np0_passthru: got send=%0b tail=%0b dest=%h data=%h cout=%0b want 1/1/15/cafe/1",
                   send_out_0, is_tail_out_0, dest_out_0, data_out_0, credit_out_0);
        end
      end else begin
        n_cmp++;
        if ({send_out_0, credit_out_0, credits_0, flit_count_0, pkt_count_0} !==
            {1'b0, 1'b0, 3'd4, 32'd1, 32'd1}) begin
          n_fail++;
          $display("FAIL np0_after cycle %0d: got send=%0b cout=%0b cred=%0d flit=%0d pkt=%0d want 0/0/4/1/1",
                   k, send_out_0, credit_out_0, credits_0, flit_count_0, pkt_count_0);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    rst_noc_sync = 1'b1;
    idle_inputs();
    test_reset();
    test_single_flit();
    test_back_to_back();
    test_underflow();
    test_overflow();
    test_reset_in_flight();
    test_np0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
